me_dual_lsu_sequencer: RTL and testbench

Memory-stage sequencer for the dual-issue pipeline, directly downstream of EX coordination. It accepts up to two memory operations per cycle (lane 1 and lane 2) and serializes them, older first, onto the single data-memory port. It produces the per-lane memory stall flags that EX consumes, and registered, sign/zero-extended load results for writeback.

---
 rtl/me_dual_lsu_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_me_dual_lsu_sequencer.sv | 468 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/me_dual_lsu_sequencer.sv
// Memory-stage sequencer: serializes up to two lane memory ops (older first)
// onto one data-memory port and returns both lanes' load results together.
module me_dual_lsu_sequencer #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        ex1_memop,
    input  logic [3:0]        ex2_memop,
    input  logic [ADDR_W-1:0] ex1_addr,
    input  logic [ADDR_W-1:0] ex2_addr,
    input  logic [DATA_W-1:0] ex1_wdata,
    input  logic [DATA_W-1:0] ex2_wdata,
    input  logic              ex2_older,
    output logic              s_me1_stall,
    output logic              s_me2_stall,
    output logic              dm_req,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [3:0]        dm_be,
    output logic [DATA_W-1:0] dm_wdata,
    input  logic              dm_ack,
    input  logic [DATA_W-1:0] dm_rdata,
    output logic              wb1_valid,
    output logic              wb2_valid,
    output logic [DATA_W-1:0] wb1_data,
    output logic [DATA_W-1:0] wb2_data,
    output logic              misalign1,
    output logic              misalign2
);

    typedef enum logic [1:0] {IDLE, OP_A, OP_B, DONE} state_t;

    function automatic logic f_valid(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd8);
    endfunction

    function automatic logic f_is_store(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd3);
    endfunction

    function automatic logic f_is_load(input logic [3:0] op);
        return (op >= 4'd4) && (op <= 4'd8);
    endfunction

    function automatic logic f_misaligned(input logic [3:0] op, input logic [1:0] a);
        logic half;
        logic word;
        half = (op == 4'd2) || (op == 4'd5) || (op == 4'd8);
        word = (op == 4'd3) || (op == 4'd6);
        return (half && a[0]) || (word && (a != 2'b00));
    endfunction

    function automatic logic [3:0] f_be(input logic [3:0] op, input logic [1:0] a);
        logic [3:0] be;
        case (op)
            4'd1, 4'd4, 4'd7: be = 4'b0001 << a;
            4'd2, 4'd5, 4'd8: be = 4'b0011 << a;
            default:          be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] f_wdata(input logic [3:0] op, input logic [31:0] wd);
        logic [31:0] d;
        case (op)
            4'd1:    d = {4{wd[7:0]}};
            4'd2:    d = {2{wd[15:0]}};
            4'd3:    d = wd;
            default: d = '0;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] f_extend(input logic [3:0] op, input logic [1:0] a,
                                             input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (a)
            2'd0:    b = rd[7:0];
            2'd1:    b = rd[15:8];
            2'd2:    b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = a[1] ? rd[31:16] : rd[15:0];
        case (op)
            4'd4:    r = {{24{b[7]}}, b};
            4'd5:    r = {{16{h[15]}}, h};
            4'd7:    r = {24'b0, b};
            4'd8:    r = {16'b0, h};
            default: r = rd;
        endcase
        return r;
    endfunction

    state_t              r_state;
    state_t              w_state_next;
    logic [3:0]          r_op    [2];
    logic [ADDR_W-1:0]   r_addr  [2];
    logic [DATA_W-1:0]   r_wdata [2];
    logic [DATA_W-1:0]   r_wb_data [2];
    logic                r_cur;
    logic                r_two;
    logic [1:0]          r_ld;
    logic [1:0]          r_mis;

    logic [3:0]          w_in_op    [2];
    logic [ADDR_W-1:0]   w_in_addr  [2];
    logic [DATA_W-1:0]   w_in_wdata [2];
    logic [1:0]          w_mis;
    logic [1:0]          w_act;
    logic                w_first;
    logic                w_accept;
    logic                w_busy;
    logic                w_req;
    logic                w_ack;
    logic [3:0]          w_cur_op;
    logic [ADDR_W-1:0]   w_cur_addr;
    logic [DATA_W-1:0]   w_cur_wdata;

    assign w_in_op[0]    = ex1_memop;
    assign w_in_op[1]    = ex2_memop;
    assign w_in_addr[0]  = ex1_addr;
    assign w_in_addr[1]  = ex2_addr;
    assign w_in_wdata[0] = ex1_wdata;
    assign w_in_wdata[1] = ex2_wdata;

    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        assign w_mis[gi] = f_misaligned(w_in_op[gi], w_in_addr[gi][1:0]);
        assign w_act[gi] = f_valid(w_in_op[gi]) & ~w_mis[gi];
    end

    // Index of the lane that goes on the bus first: the older one if active.
    assign w_first = ex2_older ? w_act[1] : ~w_act[0];

    assign w_busy   = (r_state != IDLE);
    assign w_accept = in_valid & ~w_busy;
    assign w_req    = (r_state == OP_A) || (r_state == OP_B);
    assign w_ack    = w_req & dm_ack;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) r_state <= IDLE;
        else      r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (w_accept && (w_act != 2'b00)) w_state_next = OP_A;
            OP_A: if (dm_ack) w_state_next = r_two ? OP_B : DONE;
            OP_B: if (dm_ack) w_state_next = DONE;
            DONE: w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < 2; i++) begin
                r_op[i]      <= '0;
                r_addr[i]    <= '0;
                r_wdata[i]   <= '0;
                r_wb_data[i] <= '0;
            end
            r_cur <= 1'b0;
            r_two <= 1'b0;
            r_ld  <= 2'b00;
            r_mis <= 2'b00;
        end else begin
            r_mis <= w_accept ? w_mis : 2'b00;
            if (w_accept) begin
                for (int i = 0; i < 2; i++) begin
                    r_op[i]    <= w_in_op[i];
                    r_addr[i]  <= w_in_addr[i];
                    r_wdata[i] <= w_in_wdata[i];
                end
                r_cur <= w_first;
                r_two <= &w_act;
                r_ld  <= 2'b00;
            end else if (w_ack) begin
                if (f_is_load(w_cur_op)) begin
                    r_wb_data[r_cur] <= f_extend(w_cur_op, w_cur_addr[1:0], dm_rdata);
                    r_ld[r_cur]      <= 1'b1;
                end
                if (r_state == OP_A) r_cur <= ~r_cur;
            end
        end
    end

    assign w_cur_op    = r_op[r_cur];
    assign w_cur_addr  = r_addr[r_cur];
    assign w_cur_wdata = r_wdata[r_cur];

    // Bus fields are decoded from held registers, so they stay stable for the whole request.
    assign dm_req   = w_req;
    assign dm_we    = w_req & f_is_store(w_cur_op);
    assign dm_addr  = w_req ? {w_cur_addr[ADDR_W-1:2], 2'b00} : '0;
    assign dm_be    = w_req ? f_be(w_cur_op, w_cur_addr[1:0]) : 4'b0000;
    assign dm_wdata = w_req ? f_wdata(w_cur_op, w_cur_wdata) : '0;

    assign in_ready    = ~w_busy;
    assign s_me1_stall = w_busy;
    assign s_me2_stall = w_busy;

    assign wb1_valid = (r_state == DONE) & r_ld[0];
    assign wb2_valid = (r_state == DONE) & r_ld[1];
    assign wb1_data  = r_wb_data[0];
    assign wb2_data  = r_wb_data[1];
    assign misalign1 = r_mis[0];
    assign misalign2 = r_mis[1];

endmodule

// File: tb/tb_me_dual_lsu_sequencer.sv
// Self-checking bench for me_dual_lsu_sequencer: directed scenarios plus
// randomized lane pairs checked against an arithmetic reference model.
module tb_me_dual_lsu_sequencer;

    logic        CLK = 1'b0;
    logic        RST;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  ex1_memop, ex2_memop;
    logic [31:0] ex1_addr, ex2_addr, ex1_wdata, ex2_wdata;
    logic        ex2_older;
    logic        s_me1_stall, s_me2_stall;
    logic        dm_req, dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        wb1_valid, wb2_valid;
    logic [31:0] wb1_data, wb2_data;
    logic        misalign1, misalign2;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    me_dual_lsu_sequencer #(.ADDR_W(32), .DATA_W(32)) dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
        .ex1_memop(ex1_memop), .ex2_memop(ex2_memop),
        .ex1_addr(ex1_addr), .ex2_addr(ex2_addr),
        .ex1_wdata(ex1_wdata), .ex2_wdata(ex2_wdata), .ex2_older(ex2_older),
        .s_me1_stall(s_me1_stall), .s_me2_stall(s_me2_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
        .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .wb1_valid(wb1_valid), .wb2_valid(wb2_valid),
        .wb1_data(wb1_data), .wb2_data(wb2_data),
        .misalign1(misalign1), .misalign2(misalign2)
    );

    // Observations collected by do_pair for one accepted lane pair.
    int          obs_n_ops, obs_stall1, obs_stall2, obs_ready_low;
    int          obs_wb1_n, obs_wb2_n, obs_wb1_k, obs_wb2_k;
    int          obs_mis1_n, obs_mis2_n, obs_mis1_k, obs_mis2_k;
    logic [31:0] obs_wb1_d, obs_wb2_d;
    logic        obs_we   [2];
    logic [31:0] obs_addr [2];
    logic [3:0]  obs_be   [2];
    logic [31:0] obs_wd   [2];
    logic        obs_unstable, obs_timeout;
    logic [31:0] drv_rd   [2];

    // Reference model: size in bytes of a memop, 0 when it is not a memory op.
    function automatic int msize(input logic [3:0] op);
        case (op)
            4'd1, 4'd4, 4'd7: return 1;
            4'd2, 4'd5, 4'd8: return 2;
            4'd3, 4'd6:       return 4;
            default:          return 0;
        endcase
    endfunction

    function automatic logic mmis(input logic [3:0] op, input logic [31:0] a);
        int sz;
        sz = msize(op);
        return (sz > 0) && ((a % sz) != 0);
    endfunction

    function automatic logic mact(input logic [3:0] op, input logic [31:0] a);
        return (msize(op) > 0) && !mmis(op, a);
    endfunction

    function automatic logic [3:0] mbe(input logic [3:0] op, input logic [31:0] a);
        logic [7:0] t;
        t = ((8'd1 << msize(op)) - 8'd1) << (a % 4);
        return t[3:0];
    endfunction

    function automatic logic [31:0] mwd(input logic [3:0] op, input logic [31:0] d);
        logic [31:0] b, h;
        b = {24'b0, d[7:0]};
        h = {16'b0, d[15:0]};
        if (msize(op) == 1) return b * 32'h01010101;
        if (msize(op) == 2) return h * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] mres(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] rd);
        int          bits;
        logic [31:0] v, mask;
        bits = 8 * msize(op);
        v = rd >> (8 * (a % 4));
        if (bits < 32) begin
            mask = (32'd1 << bits) - 32'd1;
            v = v & mask;
            if (((op == 4'd4) || (op == 4'd5)) && v[bits-1]) v = v | ~mask;
        end
        return v;
    endfunction

    task automatic do_pair(input logic [3:0] o1, input logic [31:0] a1, input logic [31:0] d1,
                           input logic [3:0] o2, input logic [31:0] a2, input logic [31:0] d2,
                           input logic older, input int delay, input logic inject,
                           input logic junk);
        int   k, op_idx, wcnt, lim, ri;
        logic op_start, done;
        ex1_memop = o1; ex1_addr = a1; ex1_wdata = d1;
        ex2_memop = o2; ex2_addr = a2; ex2_wdata = d2;
        ex2_older = older;
        in_valid  = 1'b1;
        @(posedge CLK);
        #1;
        in_valid  = 1'b0;
        ex1_memop = 4'd6; ex1_addr = {$urandom_range(0, 1023), 2'b00}; ex1_wdata = $urandom;
        ex2_memop = 4'd3; ex2_addr = {$urandom_range(0, 1023), 2'b00}; ex2_wdata = $urandom;
        ex2_older = ~older;
        obs_n_ops = 0; obs_stall1 = 0; obs_stall2 = 0; obs_ready_low = 0;
        obs_wb1_n = 0; obs_wb2_n = 0; obs_wb1_k = 0; obs_wb2_k = 0;
        obs_mis1_n = 0; obs_mis2_n = 0; obs_mis1_k = 0; obs_mis2_k = 0;
        obs_wb1_d = '0; obs_wb2_d = '0;
        obs_unstable = 1'b0; obs_timeout = 1'b0;
        k = 0; op_idx = 0; wcnt = 0; op_start = 1'b1; done = 1'b0;
        while (!done) begin
            @(negedge CLK);
            k++;
            if (misalign1) begin obs_mis1_n++; obs_mis1_k = k; end
            if (misalign2) begin obs_mis2_n++; obs_mis2_k = k; end
            if (s_me1_stall) obs_stall1++;
            if (s_me2_stall) obs_stall2++;
            if (!in_ready) obs_ready_low++;
            if (wb1_valid) begin obs_wb1_n++; obs_wb1_k = k; obs_wb1_d = wb1_data; end
            if (wb2_valid) begin obs_wb2_n++; obs_wb2_k = k; obs_wb2_d = wb2_data; end
            if (dm_req) begin
                if (op_start) begin
                    if (obs_n_ops < 2) begin
                        obs_we[obs_n_ops]   = dm_we;
                        obs_addr[obs_n_ops] = dm_addr;
                        obs_be[obs_n_ops]   = dm_be;
                        obs_wd[obs_n_ops]   = dm_wdata;
                    end
                    obs_n_ops++;
                    op_start = 1'b0;
                    wcnt = 0;
                end else if (obs_n_ops <= 2) begin
                    if (dm_we !== obs_we[obs_n_ops-1] || dm_addr !== obs_addr[obs_n_ops-1] ||
                        dm_be !== obs_be[obs_n_ops-1] || dm_wdata !== obs_wd[obs_n_ops-1])
                        obs_unstable = 1'b1;
                end
                lim = (op_idx == 0) ? delay : 0;
                if (wcnt >= lim) begin
                    ri = (op_idx < 2) ? op_idx : 1;
                    dm_ack   = 1'b1;
                    dm_rdata = drv_rd[ri];
                    op_idx++;
                    op_start = 1'b1;
                end else begin
                    dm_ack   = 1'b0;
                    dm_rdata = $urandom;
                    wcnt++;
                end
            end else begin
                dm_ack   = inject;
                dm_rdata = $urandom;
            end
            in_valid = junk & s_me1_stall;
            if (k >= 2 && !s_me1_stall) done = 1'b1;
            if (k >= 40) begin obs_timeout = 1'b1; done = 1'b1; end
        end
        dm_ack   = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        checks++;
        if ({dm_req, dm_we, dm_addr, dm_be, dm_wdata} !== 70'd0) begin
            errors++;
            $display("FAIL reset_bus: got req=%0b we=%0b addr=%h be=%h wd=%h, want all 0",
                     dm_req, dm_we, dm_addr, dm_be, dm_wdata);
        end
        checks++;
        if ({wb1_valid, wb2_valid, wb1_data, wb2_data, misalign1, misalign2} !== 68'd0) begin
            errors++;
            $display("FAIL reset_wb: got v=%0b%0b d1=%h d2=%h mis=%0b%0b, want all 0",
                     wb1_valid, wb2_valid, wb1_data, wb2_data, misalign1, misalign2);
        end
        checks++;
        if ({in_ready, s_me1_stall, s_me2_stall} !== 3'b100) begin
            errors++;
            $display("FAIL reset_ready: got ready=%0b stall=%0b%0b, want 1 00",
                     in_ready, s_me1_stall, s_me2_stall);
        end
        @(posedge CLK);
        #1 RST = 1'b1;
        @(negedge CLK);
        $display("test_reset done");
    endtask

    task automatic test_single_lw();
        drv_rd[0] = 32'hDEADBEEF; drv_rd[1] = 32'h0;
        do_pair(4'd6, 32'h100, 32'h0, 4'd0, 32'h0, 32'h0, 1'b0, 0, 1'b0, 1'b0);
        checks++;
        if (obs_n_ops !== 1 || obs_addr[0] !== 32'h100 || obs_be[0] !== 4'hF || obs_we[0] !== 1'b0) begin
            errors++;
            $display("FAIL single_lw_bus: got n=%0d addr=%h be=%h we=%0b, want 1 00000100 f 0",
                     obs_n_ops, obs_addr[0], obs_be[0], obs_we[0]);
        end
        checks++;
        if (obs_wb1_n !== 1 || obs_wb1_k !== 2 || obs_wb1_d !== 32'hDEADBEEF || obs_wb2_n !== 0) begin
            errors++;
            $display("FAIL single_lw_wb: got n=%0d cyc=%0d d=%h wb2n=%0d, want 1 2 deadbeef 0",
                     obs_wb1_n, obs_wb1_k, obs_wb1_d, obs_wb2_n);
        end
        checks++;
        if (obs_stall1 !== 2 || obs_stall2 !== 2 || obs_ready_low !== 2) begin
            errors++;
            $display("FAIL single_lw_stall: got %0d/%0d ready_low=%0d, want 2/2 2",
                     obs_stall1, obs_stall2, obs_ready_low);
        end
        $display("test_single_lw done");
    endtask

    task automatic test_store_load();
        drv_rd[0] = 32'h0; drv_rd[1] = 32'hA5000000;
        do_pair(4'd1, 32'h203, 32'h123456A5, 4'd7, 32'h203, 32'h0, 1'b0, 0, 1'b0, 1'b0);
        checks++;
        if (obs_n_ops !== 2 || obs_we[0] !== 1'b1 || obs_addr[0] !== 32'h200 ||
            obs_be[0] !== 4'b1000 || obs_wd[0] !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL sb_first: got n=%0d we=%0b addr=%h be=%b wd=%h, want 2 1 00000200 1000 a5a5a5a5",
                     obs_n_ops, obs_we[0], obs_addr[0], obs_be[0], obs_wd[0]);
        end
        checks++;
        if (obs_we[1] !== 1'b0 || obs_addr[1] !== 32'h200 || obs_be[1] !== 4'b1000) begin
            errors++;
            $display("FAIL lbu_second: got we=%0b addr=%h be=%b, want 0 00000200 1000",
                     obs_we[1], obs_addr[1], obs_be[1]);
        end
        checks++;
        if (obs_wb2_n !== 1 || obs_wb2_k !== 3 || obs_wb2_d !== 32'h000000A5 || obs_wb1_n !== 0) begin
            errors++;
            $display("FAIL lbu_wb: got n=%0d cyc=%0d d=%h wb1n=%0d, want 1 3 000000a5 0",
                     obs_wb2_n, obs_wb2_k, obs_wb2_d, obs_wb1_n);
        end
        $display("test_store_load done");
    endtask

    task automatic test_lh_pair();
        drv_rd[0] = 32'h80000000; drv_rd[1] = 32'h00001234;
        do_pair(4'd5, 32'h20, 32'h0, 4'd5, 32'h12, 32'h0, 1'b1, 0, 1'b0, 1'b0);
        checks++;
        if (obs_n_ops !== 2 || obs_addr[0] !== 32'h10 || obs_be[0] !== 4'b1100 ||
            obs_addr[1] !== 32'h20 || obs_be[1] !== 4'b0011) begin
            errors++;
            $display("FAIL lh_order: got n=%0d a0=%h be0=%b a1=%h be1=%b, want 2 00000010 1100 00000020 0011",
                     obs_n_ops, obs_addr[0], obs_be[0], obs_addr[1], obs_be[1]);
        end
        checks++;
        if (obs_wb2_d !== 32'hFFFF8000 || obs_wb1_d !== 32'h00001234 ||
            obs_wb1_k !== 3 || obs_wb2_k !== 3 || obs_wb1_n !== 1 || obs_wb2_n !== 1) begin
            errors++;
            $display("FAIL lh_wb: got d2=%h d1=%h cyc=%0d/%0d n=%0d/%0d, want ffff8000 00001234 3/3 1/1",
                     obs_wb2_d, obs_wb1_d, obs_wb2_k, obs_wb1_k, obs_wb2_n, obs_wb1_n);
        end
        $display("test_lh_pair done");
    endtask

    task automatic test_misaligned();
        do_pair(4'd3, 32'h101, 32'h11223344, 4'd0, 32'h0, 32'h0, 1'b0, 0, 1'b0, 1'b0);
        checks++;
        if (obs_mis1_n !== 1 || obs_mis1_k !== 1 || obs_mis2_n !== 0) begin
            errors++;
            $display("FAIL misalign_pulse: got n1=%0d cyc=%0d n2=%0d, want 1 1 0",
                     obs_mis1_n, obs_mis1_k, obs_mis2_n);
        end
        checks++;
        if (obs_n_ops !== 0 || obs_ready_low !== 0 || obs_stall1 !== 0) begin
            errors++;
            $display("FAIL misalign_nobus: got ops=%0d ready_low=%0d stall=%0d, want 0 0 0",
                     obs_n_ops, obs_ready_low, obs_stall1);
        end
        $display("test_misaligned done");
    endtask

    task automatic test_delayed_ack();
        int spurious_req;
        spurious_req = 0;
        dm_ack = 1'b1;
        repeat (2) begin
            @(negedge CLK);
            if (dm_req || !in_ready) spurious_req++;
        end
        dm_ack = 1'b0;
        checks++;
        if (spurious_req !== 0) begin
            errors++;
            $display("FAIL idle_ack: got %0d busy cycles from stray ack, want 0", spurious_req);
        end
        drv_rd[0] = 32'h0; drv_rd[1] = 32'h0;
        do_pair(4'd2, 32'h42, 32'h1234BEEF, 4'd0, 32'h0, 32'h0, 1'b0, 4, 1'b1, 1'b0);
        checks++;
        if (obs_n_ops !== 1 || obs_unstable !== 1'b0 || obs_addr[0] !== 32'h40 ||
            obs_be[0] !== 4'b1100 || obs_wd[0] !== 32'hBEEFBEEF) begin
            errors++;
            $display("FAIL delay_bus: got n=%0d unstable=%0b addr=%h be=%b wd=%h, want 1 0 00000040 1100 beefbeef",
                     obs_n_ops, obs_unstable, obs_addr[0], obs_be[0], obs_wd[0]);
        end
        checks++;
        if (obs_stall1 !== 6 || obs_wb1_n !== 0 || obs_timeout !== 1'b0) begin
            errors++;
            $display("FAIL delay_stall: got stall=%0d wb1n=%0d timeout=%0b, want 6 0 0",
                     obs_stall1, obs_wb1_n, obs_timeout);
        end
        $display("test_delayed_ack done");
    endtask

    task automatic test_reset_mid();
        ex1_memop = 4'd3; ex1_addr = 32'h400; ex1_wdata = 32'h1;
        ex2_memop = 4'd6; ex2_addr = 32'h404; ex2_wdata = 32'h0;
        ex2_older = 1'b0;
        in_valid  = 1'b1;
        @(posedge CLK);
        #1 in_valid = 1'b0;
        @(negedge CLK);
        dm_ack = 1'b1; dm_rdata = 32'h0;
        @(posedge CLK);
        #1 dm_ack = 1'b0;
        @(negedge CLK);
        checks++;
        if (dm_req !== 1'b1 || dm_addr !== 32'h404) begin
            errors++;
            $display("FAIL mid_opb: got req=%0b addr=%h, want 1 00000404", dm_req, dm_addr);
        end
        #1 RST = 1'b0;
        #1;
        checks++;
        if ({dm_req, dm_we, dm_addr, dm_be, dm_wdata, wb1_valid, wb2_valid,
             s_me1_stall, s_me2_stall, in_ready} !== 75'd1) begin
            errors++;
            $display("FAIL mid_reset: got req=%0b addr=%h be=%b stall=%0b ready=%0b, want 0 0 0 0 1",
                     dm_req, dm_addr, dm_be, s_me1_stall, in_ready);
        end
        @(posedge CLK);
        #1 RST = 1'b1;
        @(negedge CLK);
        drv_rd[0] = 32'hF00DF00D; drv_rd[1] = 32'h0;
        do_pair(4'd6, 32'h300, 32'h0, 4'd0, 32'h0, 32'h0, 1'b0, 1, 1'b0, 1'b0);
        checks++;
        if (obs_n_ops !== 1 || obs_addr[0] !== 32'h300 || obs_wb1_d !== 32'hF00DF00D ||
            obs_wb1_k !== 3 || obs_wb2_n !== 0) begin
            errors++;
            $display("FAIL after_reset: got n=%0d addr=%h d=%h cyc=%0d wb2n=%0d, want 1 00000300 f00df00d 3 0",
                     obs_n_ops, obs_addr[0], obs_wb1_d, obs_wb1_k, obs_wb2_n);
        end
        $display("test_reset_mid done");
    endtask

    task automatic test_back_to_back();
        logic [3:0]  o [2];
        logic [31:0] a [2];
        logic [31:0] d [2];
        logic        older, inj, junk, exp_ld;
        int          delay, n, ln, first, exp_k, exp_stall, wb_n, wb_k;
        int          lane_of [2];
        logic [31:0] exp_res [2];
        logic [31:0] wb_d;
        for (int it = 0; it < 40; it++) begin
            for (int j = 0; j < 2; j++) begin
                o[j] = 4'($urandom_range(0, 10));
                a[j] = $urandom_range(0, 1023);
                d[j] = $urandom;
                drv_rd[j] = $urandom;
            end
            older = 1'($urandom_range(0, 1));
            delay = $urandom_range(0, 3);
            inj   = 1'($urandom_range(0, 1));
            junk  = 1'($urandom_range(0, 1));
            do_pair(o[0], a[0], d[0], o[1], a[1], d[1], older, delay, inj, junk);

            n = 0;
            first = older ? 1 : 0;
            exp_res[0] = '0; exp_res[1] = '0;
            for (int j = 0; j < 2; j++) begin
                ln = (j == 0) ? first : 1 - first;
                if (mact(o[ln], a[ln])) begin
                    lane_of[n] = ln;
                    exp_res[ln] = mres(o[ln], a[ln], drv_rd[n]);
                    n++;
                end
            end
            exp_k     = n + delay + 1;
            exp_stall = (n > 0) ? exp_k : 0;
            checks++;
            if (obs_n_ops !== n || obs_unstable !== 1'b0 || obs_timeout !== 1'b0) begin
                errors++;
                $display("FAIL rnd%0d_ops: got n=%0d unstable=%0b timeout=%0b, want %0d 0 0",
                         it, obs_n_ops, obs_unstable, obs_timeout, n);
            end
            for (int j = 0; j < n && j < obs_n_ops && j < 2; j++) begin
                ln = lane_of[j];
                checks++;
                if (obs_we[j] !== (o[ln] <= 4'd3) || obs_addr[j] !== (a[ln] & ~32'd3) ||
                    obs_be[j] !== mbe(o[ln], a[ln]) ||
                    ((o[ln] <= 4'd3) && obs_wd[j] !== mwd(o[ln], d[ln]))) begin
                    errors++;
                    $display("FAIL rnd%0d_op%0d: got we=%0b addr=%h be=%b wd=%h, want lane%0d op=%0d addr=%h be=%b wd=%h",
                             it, j, obs_we[j], obs_addr[j], obs_be[j], obs_wd[j], ln + 1, o[ln],
                             a[ln] & ~32'd3, mbe(o[ln], a[ln]), mwd(o[ln], d[ln]));
                end
            end
            for (int j = 0; j < 2; j++) begin
                exp_ld = mact(o[j], a[j]) && (o[j] >= 4'd4);
                wb_n = (j == 0) ? obs_wb1_n : obs_wb2_n;
                wb_k = (j == 0) ? obs_wb1_k : obs_wb2_k;
                wb_d = (j == 0) ? obs_wb1_d : obs_wb2_d;
                checks++;
                if (exp_ld ? (wb_n !== 1 || wb_k !== exp_k || wb_d !== exp_res[j]) : (wb_n !== 0)) begin
                    errors++;
                    $display("FAIL rnd%0d_wb%0d: got n=%0d cyc=%0d d=%h, want load=%0b cyc=%0d d=%h",
                             it, j + 1, wb_n, wb_k, wb_d, exp_ld, exp_k, exp_res[j]);
                end
            end
            checks++;
            if (obs_mis1_n !== int'(mmis(o[0], a[0])) || obs_mis2_n !== int'(mmis(o[1], a[1])) ||
                (mmis(o[0], a[0]) && obs_mis1_k !== 1) || (mmis(o[1], a[1]) && obs_mis2_k !== 1)) begin
                errors++;
                $display("FAIL rnd%0d_mis: got n=%0d/%0d cyc=%0d/%0d, want %0b/%0b at cycle 1",
                         it, obs_mis1_n, obs_mis2_n, obs_mis1_k, obs_mis2_k,
                         mmis(o[0], a[0]), mmis(o[1], a[1]));
            end
            checks++;
            if (obs_stall1 !== exp_stall || obs_stall2 !== exp_stall || obs_ready_low !== exp_stall) begin
                errors++;
                $display("FAIL rnd%0d_stall: got %0d/%0d ready_low=%0d, want %0d",
                         it, obs_stall1, obs_stall2, obs_ready_low, exp_stall);
            end
            $display("rnd%0d ops=%h/%h addr=%h/%h older=%0b delay=%0d n=%0d",
                     it, o[0], o[1], a[0], a[1], older, delay, n);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b0; in_valid = 1'b0;
        ex1_memop = '0; ex2_memop = '0; ex1_addr = '0; ex2_addr = '0;
        ex1_wdata = '0; ex2_wdata = '0; ex2_older = 1'b0;
        dm_ack = 1'b0; dm_rdata = '0;
        drv_rd[0] = '0; drv_rd[1] = '0;
        test_reset();
        test_single_lw();
        test_store_load();
        test_lh_pair();
        test_misaligned();
        test_delayed_ack();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
